// File: rtl/adjust_ctrl.sv
// Front-panel adjust control: debounces mode/up/down buttons, walks the set-mode FSM
// and emits single-cycle count pulses (with auto-repeat) to the clock/alarm counters.

module adjust_btn #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 12
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_evt
);
  logic             r_s1, r_s2, r_lvl, r_lvl_d, r_evt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_evt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_lvl_d <= r_lvl;
      r_evt   <= r_lvl & ~r_lvl_d;
      // level flips only after DB_CYCLES consecutive disagreeing samples
      if (r_s2 == r_lvl) r_cnt <= '0;
      else if (r_cnt == CNT_W'(DB_CYCLES)) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_lvl = r_lvl;
  assign o_evt = r_evt;
endmodule

module adjust_ctrl #(
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_run_en,
  output logic [3:0] o_tgt,
  output logic       o_adj_up,
  output logic       o_adj_down,
  output logic [2:0] o_state
);
  typedef enum logic [2:0] {
    RUN = 3'd0, SET_HR = 3'd1, SET_MIN = 3'd2, SET_AHR = 3'd3, SET_AMIN = 3'd4
  } state_t;

  logic [2:0] w_raw, w_lvl, w_evt;
  assign w_raw = {i_btn_down, i_btn_up, i_btn_mode};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    adjust_btn #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_btn (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_raw (w_raw[b]),
      .o_lvl (w_lvl[b]),
      .o_evt (w_evt[b])
    );
  end

  // index 0 = up, 1 = down
  logic       w_mode_evt, w_both;
  logic [1:0] w_dir_lvl, w_dir_evt;
  assign w_mode_evt = w_evt[0];
  assign w_dir_lvl  = w_lvl[2:1];
  assign w_dir_evt  = w_evt[2:1];
  assign w_both     = &w_dir_lvl;

  state_t                 r_state, w_nxt;
  logic                   r_run_en;
  logic [3:0]             r_tgt, w_nxt_tgt;
  logic [1:0]             r_adj, r_arm, r_rep;
  logic [1:0][CNT_W-1:0]  r_hcnt;

  always_comb begin
    w_nxt     = RUN;
    w_nxt_tgt = 4'b0000;
    case (r_state)
      RUN:      begin w_nxt = SET_HR;   w_nxt_tgt = 4'b0001; end
      SET_HR:   begin w_nxt = SET_MIN;  w_nxt_tgt = 4'b0010; end
      SET_MIN:  begin w_nxt = SET_AHR;  w_nxt_tgt = 4'b0100; end
      SET_AHR:  begin w_nxt = SET_AMIN; w_nxt_tgt = 4'b1000; end
      default:  begin w_nxt = RUN;      w_nxt_tgt = 4'b0000; end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= RUN;
      r_run_en <= 1'b1;
      r_tgt    <= 4'b0000;
      r_adj    <= '0;
      r_arm    <= '0;
      r_rep    <= '0;
      r_hcnt   <= '0;
    end else begin
      r_adj <= '0;
      if (w_mode_evt) begin
        // mode wins over a coincident up/down event; a held key must be re-pressed
        r_state  <= w_nxt;
        r_tgt    <= w_nxt_tgt;
        r_run_en <= (w_nxt == RUN);
        r_arm    <= '0;
        r_rep    <= '0;
        r_hcnt   <= '0;
      end else if (r_state == RUN || w_both) begin
        r_arm  <= '0;
        r_rep  <= '0;
        r_hcnt <= '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (!w_dir_lvl[d]) begin
            r_arm[d]  <= 1'b0;
            r_rep[d]  <= 1'b0;
            r_hcnt[d] <= '0;
          end else if (w_dir_evt[d]) begin
            r_adj[d]  <= 1'b1;
            r_arm[d]  <= 1'b1;
            r_rep[d]  <= 1'b0;
            r_hcnt[d] <= '0;
          end else if (r_arm[d]) begin
            // first repeat after HOLD_CYCLES, then every REPEAT_CYCLES
            if (r_hcnt[d] == (r_rep[d] ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1))) begin
              r_adj[d]  <= 1'b1;
              r_rep[d]  <= 1'b1;
              r_hcnt[d] <= '0;
            end else r_hcnt[d] <= r_hcnt[d] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign o_state    = r_state;
  assign o_run_en   = r_run_en;
  assign o_tgt      = r_tgt;
  assign o_adj_up   = r_adj[0];
  assign o_adj_down = r_adj[1];
endmodule

// File: tb/tb_adjust_ctrl.sv
// Scoreboard bench for adjust_ctrl: expected state changes and adj pulses are queued
// with their exact output cycle when buttons are driven, and checked as the DUT emits them.

module tb_adjust_ctrl;
  localparam int DB = 16, HOLD = 1000, REP = 250;

  logic       clk = 1'b0, rst = 1'b0;
  logic [2:0] btns = '0;  // {down, up, mode}
  logic       run_en, adj_up, adj_down;
  logic [3:0] tgt;
  logic [2:0] state;

  int n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct { int kind; int cyc; logic [2:0] st; } exp_t;  // kind: 0 state, 1 up, 2 down
  exp_t       sb[$];
  exp_t       e_m;
  logic [2:0] m_st = '0, prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adjust_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(12)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn_mode (btns[0]),
    .i_btn_up   (btns[1]),
    .i_btn_down (btns[2]),
    .o_run_en   (run_en),
    .o_tgt      (tgt),
    .o_adj_up   (adj_up),
    .o_adj_down (adj_down),
    .o_state    (state)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] tgt_of(input logic [2:0] s);
    case (s)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // monitor: every output event must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) prev = '0;
    else if (adj_up || adj_down || state != prev) begin
      if (sb.size() == 0) chk("unexpected_output_cycle", cyc, -1);
      else begin
        e_m = sb.pop_front();
        chk("kind",   adj_up ? 1 : adj_down ? 2 : 0, e_m.kind);
        chk("cycle",  cyc, e_m.cyc);
        chk("state",  state, e_m.st);
        chk("tgt",    tgt, tgt_of(e_m.st));
        chk("run_en", run_en, e_m.st == 3'd0);
        chk("both_adj", adj_up & adj_down, 0);
      end
      prev = state;
    end
  end

  task automatic push(input int kind, input int c, input logic [2:0] st);
    exp_t e;
    e.kind = kind; e.cyc = c; e.st = st;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2:0] mask, input logic [2:0] val, output int k);
    @(negedge clk);
    btns = (btns & ~mask) | (val & mask);
    k = cyc + 1;  // first rising edge that samples the new level
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] nxt(input logic [2:0] s);
    return (s == 3'd4) ? 3'd0 : s + 3'd1;
  endfunction

  task automatic mode_press();
    int k;
    drive(3'b001, 3'b001, k);
    m_st = nxt(m_st);
    push(0, k + DB + 4, m_st);
    idle(40);
    drive(3'b001, 3'b000, k);
    idle(30);
  endtask

  // d: 1 = up, 2 = down; raw press of dur cycles
  task automatic dir_press(input int d, input int dur);
    int k;
    logic [2:0] m;
    m = (d == 1) ? 3'b010 : 3'b100;
    drive(m, m, k);
    if (m_st != 3'd0 && dur > DB) begin
      push(d, k + DB + 4, m_st);
      for (int x = HOLD; x <= dur - 2; x += (x == HOLD && HOLD != 0 ? REP : REP)) push(d, k + DB + 4 + x, m_st);
    end
    idle(dur);
    drive(m, 3'b000, k);
    idle(30);
  endtask

  initial begin
    int k;
    idle(3);
    chk("rst_state",  state, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_tgt",    tgt, 0);
    chk("rst_adj_up", adj_up, 0);
    chk("rst_adj_dn", adj_down, 0);
    @(negedge clk); rst = 1'b1;
    idle(100);
    chk("idle_state", state, 0);

    mode_press();                 // -> SET_HR
    dir_press(2, 1600);           // initial + repeats at +1000, +1250, +1500

    mode_press();                 // -> SET_MIN
    dir_press(1, 10);             // glitch: nothing
    dir_press(1, 30);             // single up pulse

    mode_press();                 // -> SET_AHR
    drive(3'b110, 3'b110, k);     // up+down together: nothing
    idle(40);
    drive(3'b100, 3'b000, k);
    idle(1200);                   // up still held but not armed: no repeat
    drive(3'b010, 3'b000, k);
    idle(30);
    dir_press(1, 30);             // fresh press works again

    drive(3'b011, 3'b011, k);     // mode + up same cycle: mode wins
    m_st = nxt(m_st);
    push(0, k + DB + 4, m_st);
    idle(40);
    drive(3'b011, 3'b000, k);
    idle(30);

    mode_press();                 // -> RUN
    dir_press(1, 30);             // ignored in RUN
    mode_press();                 // -> SET_HR
    mode_press();                 // -> SET_MIN

    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_state",  state, 0);
    chk("async_rst_run_en", run_en, 1);
    chk("async_rst_tgt",    tgt, 0);
    m_st = '0;
    btns[0] = 1'b1;               // mode held across reset release
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    k = cyc + 1;
    m_st = 3'd1;
    push(0, k + DB + 4, m_st);
    idle(40);
    drive(3'b001, 3'b000, k);
    idle(40);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
